// File: rtl/render_lines.sv
// Table-driven multi-line renderer: fetches each segment from a synchronous table, scales it
// and rasterises it with an integrated Bresenham line engine feeding the framebuffer port.
module render_lines #(
  parameter int unsigned CORDW = 16,
  parameter int unsigned CIDXW = 4,
  parameter int unsigned SCALE = 1,
  parameter int unsigned LINES = 8,
  parameter int unsigned LOOP  = 0,
  localparam int unsigned IDXW = (LINES > 1) ? $clog2(LINES) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     oe,
  input  logic                     start,
  output logic [IDXW-1:0]          tbl_addr,
  input  logic [4*CORDW+CIDXW-1:0] tbl_data,
  output logic signed [CORDW-1:0]  x,
  output logic signed [CORDW-1:0]  y,
  output logic [CIDXW-1:0]         cidx,
  output logic                     drawing,
  output logic                     busy,
  output logic [IDXW-1:0]          line_idx,
  output logic                     done
);

  localparam int unsigned DW = CORDW + 1;
  localparam int unsigned EW = CORDW + 3;

  typedef enum logic [2:0] {StIdle, StFetch, StLoad, StDraw, StNext, StDone} state_e;
  typedef enum logic [1:0] {EngIdle, EngInit, EngRun} eng_e;

  state_e                  state_q, state_d;
  logic [IDXW-1:0]         idx_q, idx_d;
  logic                    load_en;
  logic                    draw_start_q, draw_start_d;
  logic                    draw_done_q, draw_done_d;
  logic signed [CORDW-1:0] x0_q, y0_q, x1_q, y1_q;
  logic [CIDXW-1:0]        cidx_q;

  // Product truncated to CORDW bits: overflow wraps in two's complement, no clipping.
  logic signed [CORDW-1:0] x0_s, y0_s, x1_s, y1_s;
  logic [CIDXW-1:0]        cidx_t;

  assign x0_s   = tbl_data[0*CORDW +: CORDW] * CORDW'(SCALE);
  assign y0_s   = tbl_data[1*CORDW +: CORDW] * CORDW'(SCALE);
  assign x1_s   = tbl_data[2*CORDW +: CORDW] * CORDW'(SCALE);
  assign y1_s   = tbl_data[3*CORDW +: CORDW] * CORDW'(SCALE);
  assign cidx_t = tbl_data[4*CORDW +: CIDXW];

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    load_en      = 1'b0;
    draw_start_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFetch;
          idx_d   = '0;
        end
      end
      StFetch: state_d = StLoad;
      StLoad: begin
        load_en = 1'b1;
        if (cidx_t == '0) begin
          state_d = StNext;
        end else begin
          draw_start_d = 1'b1;
          state_d      = StDraw;
        end
      end
      StDraw: begin
        if (draw_done_q) state_d = StNext;
      end
      StNext: begin
        if (idx_q < IDXW'(LINES - 1)) begin
          idx_d   = idx_q + IDXW'(1);
          state_d = StFetch;
        end else begin
          state_d = StDone;
        end
      end
      StDone: begin
        idx_d   = '0;
        state_d = (LOOP != 0) ? StFetch : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      draw_start_q <= 1'b0;
      x0_q         <= '0;
      y0_q         <= '0;
      x1_q         <= '0;
      y1_q         <= '0;
      cidx_q       <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      draw_start_q <= draw_start_d;
      if (load_en) begin
        x0_q   <= x0_s;
        y0_q   <= y0_s;
        x1_q   <= x1_s;
        y1_q   <= y1_s;
        cidx_q <= cidx_t;
      end
    end
  end

  // Line engine: endpoints inclusive, one pixel per cycle while oe is high.
  eng_e                    eng_q, eng_d;
  logic signed [CORDW-1:0] ex_q, ex_d, ey_q, ey_d;
  logic signed [DW-1:0]    dx_q, dx_d, dy_q, dy_d;
  logic signed [EW-1:0]    err_q, err_d;
  logic                    sx_q, sx_d, sy_q, sy_d;
  logic signed [DW-1:0]    ddx, ddy;
  logic signed [EW-1:0]    e2, err_x, err_y;
  logic                    at_end;

  always_comb begin
    eng_d       = eng_q;
    ex_d        = ex_q;
    ey_d        = ey_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    err_d       = err_q;
    sx_d        = sx_q;
    sy_d        = sy_q;
    draw_done_d = 1'b0;
    ddx         = DW'(x1_q) - DW'(x0_q);
    ddy         = DW'(y1_q) - DW'(y0_q);
    e2          = err_q <<< 1;
    err_x       = '0;
    err_y       = '0;
    at_end      = (ex_q == x1_q) && (ey_q == y1_q);
    unique case (eng_q)
      EngIdle: begin
        if (draw_start_q) eng_d = EngInit;
      end
      EngInit: begin
        ex_d  = x0_q;
        ey_d  = y0_q;
        dx_d  = ddx[DW-1] ? -ddx : ddx;
        // dy is kept as the negated magnitude so both error updates are additions
        dy_d  = ddy[DW-1] ? ddy : -ddy;
        sx_d  = x0_q < x1_q;
        sy_d  = y0_q < y1_q;
        err_d = EW'(dx_d) + EW'(dy_d);
        eng_d = EngRun;
      end
      EngRun: begin
        if (oe) begin
          if (at_end) begin
            eng_d       = EngIdle;
            draw_done_d = 1'b1;
          end else begin
            if (e2 >= EW'(dy_q)) begin
              err_x = EW'(dy_q);
              if (sx_q) ex_d = ex_q + CORDW'(1);
              else      ex_d = ex_q - CORDW'(1);
            end
            if (e2 <= EW'(dx_q)) begin
              err_y = EW'(dx_q);
              if (sy_q) ey_d = ey_q + CORDW'(1);
              else      ey_d = ey_q - CORDW'(1);
            end
            err_d = err_q + err_x + err_y;
          end
        end
      end
      default: eng_d = EngIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      eng_q       <= EngIdle;
      ex_q        <= '0;
      ey_q        <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      err_q       <= '0;
      sx_q        <= 1'b0;
      sy_q        <= 1'b0;
      draw_done_q <= 1'b0;
    end else begin
      eng_q       <= eng_d;
      ex_q        <= ex_d;
      ey_q        <= ey_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      err_q       <= err_d;
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      draw_done_q <= draw_done_d;
    end
  end

  assign tbl_addr = idx_q;
  assign line_idx = idx_q;
  assign x        = ex_q;
  assign y        = ey_q;
  assign cidx     = cidx_q;
  assign drawing  = (eng_q == EngRun) && oe;
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);

endmodule

// File: tb/tb_render_lines.sv
// Scoreboard bench for render_lines: a one-shot instance (4 lines, scale 2) and a looping
// instance (2 lines, scale 1), each checked against a plain Bresenham reference model.
module tb_render_lines;

  localparam int CORDW = 16;
  localparam int CIDXW = 4;
  localparam int TW    = 4*CORDW + CIDXW;
  localparam int LA    = 4;
  localparam int SA    = 2;
  localparam int IA    = 2;
  localparam int LB    = 2;
  localparam int IB    = 1;

  typedef struct {int x; int y; int c;} pix_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst_a, oe_a, start_a, drw_a, busy_a, done_a;
  logic [IA-1:0]           addr_a, lidx_a;
  logic [TW-1:0]           data_a;
  logic signed [CORDW-1:0] x_a, y_a;
  logic [CIDXW-1:0]        c_a;

  logic                    rst_b, oe_b, start_b, drw_b, busy_b, done_b;
  logic [IB-1:0]           addr_b, lidx_b;
  logic [TW-1:0]           data_b;
  logic signed [CORDW-1:0] x_b, y_b;
  logic [CIDXW-1:0]        c_b;

  logic [TW-1:0] tbl_a [LA];
  logic [TW-1:0] tbl_b [LB];

  always @(posedge clk) data_a <= tbl_a[addr_a];
  always @(posedge clk) data_b <= tbl_b[addr_b];

  render_lines #(.CORDW(CORDW), .CIDXW(CIDXW), .SCALE(SA), .LINES(LA), .LOOP(0)) dut_a (
    .clk(clk), .rst(rst_a), .oe(oe_a), .start(start_a), .tbl_addr(addr_a), .tbl_data(data_a),
    .x(x_a), .y(y_a), .cidx(c_a), .drawing(drw_a), .busy(busy_a), .line_idx(lidx_a),
    .done(done_a)
  );

  render_lines #(.CORDW(CORDW), .CIDXW(CIDXW), .SCALE(1), .LINES(LB), .LOOP(1)) dut_b (
    .clk(clk), .rst(rst_b), .oe(oe_b), .start(start_b), .tbl_addr(addr_b), .tbl_data(data_b),
    .x(x_b), .y(y_b), .cidx(c_b), .drawing(drw_b), .busy(busy_b), .line_idx(lidx_b),
    .done(done_b)
  );

  int   checks = 0;
  int   failures = 0;
  pix_t qa[$];
  pix_t qb[$];
  int   drw_cnt_a = 0, done_cnt_a = 0, l1_cnt_a = 0, exp_cnt_a = 0;
  int   done_cnt_b = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  function automatic logic [TW-1:0] ent(input int x0, y0, x1, y1, c);
    return {CIDXW'(c), CORDW'(y1), CORDW'(x1), CORDW'(y0), CORDW'(x0)};
  endfunction

  // Reference rasteriser: textbook integer Bresenham over the scaled endpoints.
  task automatic model_line(input bit which, input int s, input logic [TW-1:0] e);
    int   x0, y0, x1, y1, c, dx, dy, sx, sy, err, e2, px, py;
    pix_t p;
    x0 = s * int'($signed(e[0*CORDW +: CORDW]));
    y0 = s * int'($signed(e[1*CORDW +: CORDW]));
    x1 = s * int'($signed(e[2*CORDW +: CORDW]));
    y1 = s * int'($signed(e[3*CORDW +: CORDW]));
    c  = int'(e[4*CORDW +: CIDXW]);
    if (c == 0) return;
    dx  = (x1 > x0) ? x1 - x0 : x0 - x1;
    dy  = (y1 > y0) ? y0 - y1 : y1 - y0;
    sx  = (x0 < x1) ? 1 : -1;
    sy  = (y0 < y1) ? 1 : -1;
    err = dx + dy;
    px  = x0;
    py  = y0;
    for (int k = 0; k < 4096; k++) begin
      p.x = px; p.y = py; p.c = c;
      if (which == 1'b0) begin qa.push_back(p); exp_cnt_a++; end
      else qb.push_back(p);
      if (px == x1 && py == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; px += sx; end
      if (e2 <= dx) begin err += dx; py += sy; end
    end
  endtask

  task automatic push_pass(input bit which);
    if (which == 1'b0) for (int i = 0; i < LA; i++) model_line(1'b0, SA, tbl_a[i]);
    else               for (int i = 0; i < LB; i++) model_line(1'b1, 1, tbl_b[i]);
  endtask

  // Monitors: pop and compare on every drawing cycle, sampled on the falling edge.
  initial begin
    pix_t e;
    forever begin
      @(negedge clk);
      if (drw_a) begin
        drw_cnt_a++;
        if (qa.size() == 0) flag("a_unexpected_pixel");
        else begin
          e = qa.pop_front();
          chk("a_pix_x", x_a, e.x);
          chk("a_pix_y", y_a, e.y);
          chk("a_pix_cidx", c_a, e.c);
        end
      end
      if (done_a) done_cnt_a++;
      if (busy_a && lidx_a == IA'(1)) l1_cnt_a++;
    end
  end

  initial begin
    pix_t e;
    bit   prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_done) begin
        chk("b_fetch_after_done_addr", addr_b, 0);
        chk("b_busy_after_done", busy_b, 1);
      end
      prev_done = done_b;
      if (drw_b) begin
        if (qb.size() == 0) flag("b_unexpected_pixel");
        else begin
          e = qb.pop_front();
          chk("b_pix_x", x_b, e.x);
          chk("b_pix_y", y_b, e.y);
          chk("b_pix_cidx", c_b, e.c);
        end
      end
      if (done_b) done_cnt_b++;
    end
  end

  task automatic chk_reset_a(input string tag);
    chk({tag, "_x"}, x_a, 0);
    chk({tag, "_y"}, y_a, 0);
    chk({tag, "_cidx"}, c_a, 0);
    chk({tag, "_drawing"}, drw_a, 0);
    chk({tag, "_busy"}, busy_a, 0);
    chk({tag, "_done"}, done_a, 0);
    chk({tag, "_addr"}, addr_a, 0);
    chk({tag, "_line_idx"}, lidx_a, 0);
  endtask

  task automatic pulse_start_a();
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
  endtask

  task automatic wait_done_a(input int budget, input bit rnd);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < budget) begin
      @(posedge clk); #1;
      if (rnd) oe_a = ($urandom_range(9, 0) < 8);
      @(negedge clk);
      seen = done_a;
      n++;
    end
    oe_a = 1'b1;
    chk("a_done_seen", seen, 1);
  endtask

  task automatic long_table_a();
    tbl_a[0] = ent(0, 0, 20, 0, 2);
    for (int i = 1; i < LA; i++) tbl_a[i] = ent(1, 1, 5, 5, 0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int base, n, dc;
    rst_a = 1'b1; oe_a = 1'b1; start_a = 1'b0;
    rst_b = 1'b1; oe_b = 1'b1; start_b = 1'b0;
    for (int i = 0; i < LA; i++) tbl_a[i] = '0;
    for (int i = 0; i < LB; i++) tbl_b[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    chk_reset_a("reset");
    chk("reset_b_busy", busy_b, 0);
    chk("reset_b_addr", addr_b, 0);

    // Transparent line 1, scaled line 2, vertical line 3.
    tbl_a[0] = ent(0, 0, 3, 0, 3);
    tbl_a[1] = ent(5, 5, 9, 9, 0);
    tbl_a[2] = ent(1, 1, 2, 1, 7);
    tbl_a[3] = ent(0, 0, 0, 2, 5);
    exp_cnt_a = 0; drw_cnt_a = 0; l1_cnt_a = 0; dc = done_cnt_a;
    push_pass(1'b0);
    pulse_start_a();
    @(negedge clk);
    chk("start_busy", busy_a, 1);
    chk("start_addr", addr_a, 0);
    wait_done_a(500, 1'b0);
    chk("busy_at_done", busy_a, 1);
    @(negedge clk);
    chk("busy_after_done", busy_a, 0);
    chk("addr_after_done", addr_a, 0);
    chk("done_width", done_a, 0);
    chk("pixels_left", qa.size(), 0);
    chk("drawing_cycles", drw_cnt_a, exp_cnt_a);
    chk("skip_line_idx_cycles", l1_cnt_a, 3);
    chk("done_pulses", done_cnt_a - dc, 1);

    // Stall oe for 5 cycles mid-line: position must hold on the next pixel to draw.
    long_table_a();
    push_pass(1'b0);
    base = drw_cnt_a;
    pulse_start_a();
    n = 0;
    do begin @(posedge clk); n++; end while (drw_cnt_a - base < 5 && n < 200);
    #1 oe_a = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_drawing", drw_a, 0);
      if (qa.size() > 0) begin
        chk("stall_x", x_a, qa[0].x);
        chk("stall_y", y_a, qa[0].y);
      end else flag("stall_queue_empty");
      @(posedge clk);
      #1;
    end
    oe_a = 1'b1;
    wait_done_a(500, 1'b0);
    @(negedge clk);
    chk("stall_pixels_left", qa.size(), 0);

    // start while busy is ignored and not queued.
    push_pass(1'b0);
    dc = done_cnt_a;
    pulse_start_a();
    repeat (12) @(posedge clk);
    #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    wait_done_a(500, 1'b0);
    repeat (10) @(negedge clk);
    chk("busy_start_done_pulses", done_cnt_a - dc, 1);
    chk("busy_start_idle", busy_a, 0);
    chk("busy_start_pixels_left", qa.size(), 0);

    // Reset mid-draw, then a fresh start redraws from line 0.
    push_pass(1'b0);
    pulse_start_a();
    repeat (15) @(posedge clk);
    #1 rst_a = 1'b1;
    @(posedge clk); #1 rst_a = 1'b0;
    @(negedge clk);
    chk_reset_a("midreset");
    qa.delete();
    push_pass(1'b0);
    pulse_start_a();
    wait_done_a(500, 1'b0);
    @(negedge clk);
    chk("after_reset_pixels_left", qa.size(), 0);

    // Randomised tables with random oe stalls.
    for (int it = 0; it < 15; it++) begin
      for (int i = 0; i < LA; i++)
        tbl_a[i] = ent(int'($urandom_range(60, 0)) - 30, int'($urandom_range(60, 0)) - 30,
                       int'($urandom_range(60, 0)) - 30, int'($urandom_range(60, 0)) - 30,
                       ($urandom_range(3, 0) == 0) ? 0 : int'($urandom_range(15, 1)));
      dc = done_cnt_a;
      push_pass(1'b0);
      pulse_start_a();
      wait_done_a(3000, 1'b1);
      @(negedge clk);
      chk("rand_pixels_left", qa.size(), 0);
      chk("rand_done_pulses", done_cnt_a - dc, 1);
    end

    // Loop mode: three identical passes, done followed directly by fetch of line 0.
    tbl_b[0] = ent(0, 0, 3, 0, 3);
    tbl_b[1] = ent(0, 0, 0, 2, 5);
    for (int p = 0; p < 3; p++) push_pass(1'b1);
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    n = 0;
    while (done_cnt_b < 3 && n < 500) begin @(negedge clk); n++; end
    chk("loop_done_pulses", done_cnt_b, 3);
    @(negedge clk);
    @(posedge clk); #1 rst_b = 1'b1;
    @(posedge clk); #1 rst_b = 1'b0;
    @(negedge clk);
    chk("loop_pixels_left", qb.size(), 0);
    chk("loop_reset_busy", busy_b, 0);
    chk("loop_reset_drawing", drw_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
